axi_master_arbiter: RTL

Two-master, one-slave AXI4 arbiter sitting between the CPU core and the address crossbar. Master 0 is the instruction fetch unit (read-only); master 1 is the load/store unit (read and write). The block grants the single downstream AXI4 port to one master per transaction. It holds the grant until that transaction's final response handshake, and alternates round-robin when both masters contend.

---
 rtl/axi_master_arbiter_pkg.sv | 17 +
 rtl/axi_master_arbiter_rr_picker_2.sv | 31 +++
 rtl/axi_master_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_arbiter_pkg.sv
// Shared FSM states, master indices and channel field widths for the two-master AXI arbiter.
package axi_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  localparam int ID_W  = 4;
  localparam int LEN_W = 8;

endpackage

// File: rtl/axi_master_arbiter_rr_picker_2.sv
// Combinational two-way round-robin picker: one-hot grant, the pointer moves only on contention.
// Zero latency; with enable low it grants nothing and holds the pointer.
module axi_master_arbiter_rr_picker_2
  import axi_master_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_next_last
);

  always_comb begin
    o_gnt       = 2'b00;
    o_next_last = i_last;
    if (i_en) begin
      if (i_req == 2'b11) begin
        if (i_last == M_LSU) begin
          o_gnt       = 2'b01;
          o_next_last = M_IFU;
        end else begin
          o_gnt       = 2'b10;
          o_next_last = M_LSU;
        end
      end else begin
        o_gnt = i_req;
      end
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Grants the downstream AXI4 port to IFU or LSU for one whole transaction, round-robin on contention.
// One dead IDLE cycle per grant; all forwarding is combinational and backpressure passes straight through.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_ifu_araddr,
  input  logic              i_ifu_arvalid,
  input  logic [ID_W-1:0]   i_ifu_arid,
  input  logic [LEN_W-1:0]  i_ifu_arlen,
  input  logic [2:0]        i_ifu_arsize,
  input  logic [1:0]        i_ifu_arburst,
  output logic              o_ifu_arready,
  output logic [DATA_W-1:0] o_ifu_rdata,
  output logic [1:0]        o_ifu_rresp,
  output logic              o_ifu_rvalid,
  output logic              o_ifu_rlast,
  output logic [ID_W-1:0]   o_ifu_rid,
  input  logic              i_ifu_rready,
  input  logic [ADDR_W-1:0] i_lsu_araddr,
  input  logic              i_lsu_arvalid,
  input  logic [ID_W-1:0]   i_lsu_arid,
  input  logic [LEN_W-1:0]  i_lsu_arlen,
  input  logic [2:0]        i_lsu_arsize,
  input  logic [1:0]        i_lsu_arburst,
  output logic              o_lsu_arready,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic [1:0]        o_lsu_rresp,
  output logic              o_lsu_rvalid,
  output logic              o_lsu_rlast,
  output logic [ID_W-1:0]   o_lsu_rid,
  input  logic              i_lsu_rready,
  input  logic [ADDR_W-1:0] i_lsu_awaddr,
  input  logic              i_lsu_awvalid,
  input  logic [ID_W-1:0]   i_lsu_awid,
  input  logic [LEN_W-1:0]  i_lsu_awlen,
  input  logic [2:0]        i_lsu_awsize,
  input  logic [1:0]        i_lsu_awburst,
  output logic              o_lsu_awready,
  input  logic [DATA_W-1:0] i_lsu_wdata,
  input  logic [DATA_W/8-1:0] i_lsu_wstrb,
  input  logic              i_lsu_wvalid,
  input  logic              i_lsu_wlast,
  output logic              o_lsu_wready,
  output logic [1:0]        o_lsu_bresp,
  output logic              o_lsu_bvalid,
  output logic [ID_W-1:0]   o_lsu_bid,
  input  logic              i_lsu_bready,
  output logic [ADDR_W-1:0] o_s_araddr,
  output logic              o_s_arvalid,
  output logic [ID_W-1:0]   o_s_arid,
  output logic [LEN_W-1:0]  o_s_arlen,
  output logic [2:0]        o_s_arsize,
  output logic [1:0]        o_s_arburst,
  input  logic              i_s_arready,
  input  logic [DATA_W-1:0] i_s_rdata,
  input  logic [1:0]        i_s_rresp,
  input  logic              i_s_rvalid,
  input  logic              i_s_rlast,
  input  logic [ID_W-1:0]   i_s_rid,
  output logic              o_s_rready,
  output logic [ADDR_W-1:0] o_s_awaddr,
  output logic              o_s_awvalid,
  output logic [ID_W-1:0]   o_s_awid,
  output logic [LEN_W-1:0]  o_s_awlen,
  output logic [2:0]        o_s_awsize,
  output logic [1:0]        o_s_awburst,
  input  logic              i_s_awready,
  output logic [DATA_W-1:0] o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic              o_s_wvalid,
  output logic              o_s_wlast,
  input  logic              i_s_wready,
  input  logic [1:0]        i_s_bresp,
  input  logic              i_s_bvalid,
  input  logic [ID_W-1:0]   i_s_bid,
  output logic              o_s_bready
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic [1:0] w_gnt;
  logic       w_lsu_rd_req;
  logic       w_lsu_wr_req;

  assign w_lsu_rd_req = i_lsu_arvalid;
  assign w_lsu_wr_req = i_lsu_awvalid & i_lsu_wvalid;

  axi_master_arbiter_rr_picker_2 u_picker (
    .i_req       ({w_lsu_rd_req | w_lsu_wr_req, i_ifu_arvalid}),
    .i_last      (r_last),
    .i_en        (r_state == IDLE),
    .o_gnt       (w_gnt),
    .o_next_last (w_last_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= M_LSU;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // LSU read beats LSU write when both are pending.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_gnt[M_IFU])      w_state_nxt = IFU_RD;
        else if (w_gnt[M_LSU]) w_state_nxt = w_lsu_rd_req ? LSU_RD : LSU_WR;
      end
      IFU_RD, LSU_RD: if (i_s_rvalid & o_s_rready & i_s_rlast) w_state_nxt = IDLE;
      LSU_WR:         if (i_s_bvalid & o_s_bready) w_state_nxt = IDLE;
      default:        w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ifu_arready = 1'b0;
    o_ifu_rdata   = '0;
    o_ifu_rresp   = '0;
    o_ifu_rvalid  = 1'b0;
    o_ifu_rlast   = 1'b0;
    o_ifu_rid     = '0;
    o_lsu_arready = 1'b0;
    o_lsu_rdata   = '0;
    o_lsu_rresp   = '0;
    o_lsu_rvalid  = 1'b0;
    o_lsu_rlast   = 1'b0;
    o_lsu_rid     = '0;
    o_lsu_awready = 1'b0;
    o_lsu_wready  = 1'b0;
    o_lsu_bresp   = '0;
    o_lsu_bvalid  = 1'b0;
    o_lsu_bid     = '0;
    o_s_araddr    = '0;
    o_s_arvalid   = 1'b0;
    o_s_arid      = '0;
    o_s_arlen     = '0;
    o_s_arsize    = '0;
    o_s_arburst   = '0;
    o_s_rready    = 1'b0;
    o_s_awaddr    = '0;
    o_s_awvalid   = 1'b0;
    o_s_awid      = '0;
    o_s_awlen     = '0;
    o_s_awsize    = '0;
    o_s_awburst   = '0;
    o_s_wdata     = '0;
    o_s_wstrb     = '0;
    o_s_wvalid    = 1'b0;
    o_s_wlast     = 1'b0;
    o_s_bready    = 1'b0;
    case (r_state)
      IFU_RD: begin
        o_s_araddr    = i_ifu_araddr;
        o_s_arvalid   = i_ifu_arvalid;
        o_s_arid      = i_ifu_arid;
        o_s_arlen     = i_ifu_arlen;
        o_s_arsize    = i_ifu_arsize;
        o_s_arburst   = i_ifu_arburst;
        o_ifu_arready = i_s_arready;
        o_ifu_rdata   = i_s_rdata;
        o_ifu_rresp   = i_s_rresp;
        o_ifu_rvalid  = i_s_rvalid;
        o_ifu_rlast   = i_s_rlast;
        o_ifu_rid     = i_s_rid;
        o_s_rready    = i_ifu_rready;
      end
      LSU_RD: begin
        o_s_araddr    = i_lsu_araddr;
        o_s_arvalid   = i_lsu_arvalid;
        o_s_arid      = i_lsu_arid;
        o_s_arlen     = i_lsu_arlen;
        o_s_arsize    = i_lsu_arsize;
        o_s_arburst   = i_lsu_arburst;
        o_lsu_arready = i_s_arready;
        o_lsu_rdata   = i_s_rdata;
        o_lsu_rresp   = i_s_rresp;
        o_lsu_rvalid  = i_s_rvalid;
        o_lsu_rlast   = i_s_rlast;
        o_lsu_rid     = i_s_rid;
        o_s_rready    = i_lsu_rready;
      end
      LSU_WR: begin
        o_s_awaddr    = i_lsu_awaddr;
        o_s_awvalid   = i_lsu_awvalid;
        o_s_awid      = i_lsu_awid;
        o_s_awlen     = i_lsu_awlen;
        o_s_awsize    = i_lsu_awsize;
        o_s_awburst   = i_lsu_awburst;
        o_lsu_awready = i_s_awready;
        o_s_wdata     = i_lsu_wdata;
        o_s_wstrb     = i_lsu_wstrb;
        o_s_wvalid    = i_lsu_wvalid;
        o_s_wlast     = i_lsu_wlast;
        o_lsu_wready  = i_s_wready;
        o_lsu_bresp   = i_s_bresp;
        o_lsu_bvalid  = i_s_bvalid;
        o_lsu_bid     = i_s_bid;
        o_s_bready    = i_lsu_bready;
      end
      default: ;
    endcase
  end

endmodule
